gpr_wb_sched: RTL and testbench

Write-back scheduler and scoreboard for the 16-entry general-purpose register file. It tracks which destination registers have an outstanding write, reports read-operand hazards to decode, and blocks WAW issue. It also arbitrates three write-back requesters (0 = ALU, 1 = LSU, 2 = CSR/debug) onto the register file's single write port. It sits between decode/execute and the register file and drives that file's `rd`, `write_data` and `write_enable` inputs.

---
 rtl/gpr_wb_sched.sv | 117 +++++++++++
 tb/tb_gpr_wb_sched.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/gpr_wb_sched.sv
// gpr_wb_sched: scoreboard and write-back scheduler for the 16-entry GPR file.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   issue_valid/issue_rd     decode issuing an instruction that writes issue_rd
//   issue_ready              destination not busy; the issue is accepted
//   rs1/rs2, rs1_busy/rs2_busy  operand hazard lookup (combinational)
//   wb_valid/wb_rd/wb_data   three write-back requesters (0 ALU, 1 LSU, 2 CSR/debug)
//   wb_ready                 one-hot round-robin grant (completed handshake)
//   gpr_we/gpr_rd/gpr_wdata  registered register-file write port
//
// Register indices use bits [3:0]. Bit 4 is carried to gpr_rd but not decoded.
module gpr_wb_sched #(
  parameter int NUM_REGS = 16,
  parameter int XLEN     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  output logic                 issue_ready,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  input  logic [2:0]           wb_valid,
  input  logic [2:0][4:0]      wb_rd,
  input  logic [2:0][XLEN-1:0] wb_data,
  output logic [2:0]           wb_ready,
  output logic                 gpr_we,
  output logic [4:0]           gpr_rd,
  output logic [XLEN-1:0]      gpr_wdata
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [1:0]          last_q, last_d;
  logic                gpr_we_q, gpr_we_d;
  logic [4:0]          gpr_rd_q, gpr_rd_d;
  logic [XLEN-1:0]     gpr_wdata_q, gpr_wdata_d;

  logic       gnt_any;
  logic [1:0] gnt_idx;
  logic       issue_fire;

  // Bit 4 of the read/issue indices and of the registered rd is not decoded.
  logic unused_idx_bits;
  assign unused_idx_bits = ^{issue_rd[4], rs1[4], rs2[4], gpr_rd_q[4]};

  assign rs1_busy    = busy_q[rs1[3:0]];
  assign rs2_busy    = busy_q[rs2[3:0]];
  // Held low during reset so decode cannot issue into a scoreboard being cleared.
  assign issue_ready = !rst && !busy_q[issue_rd[3:0]];
  assign issue_fire  = issue_valid && issue_ready && (issue_rd[3:0] != 4'd0);

  // Round-robin: search starts at last+1 (mod 3); first valid requester wins.
  always_comb begin
    int s;
    gnt_any  = 1'b0;
    gnt_idx  = 2'd0;
    wb_ready = 3'b000;
    s        = 0;
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        s = (int'(last_q) + 1 + k) % 3;
        if (!gnt_any && wb_valid[s]) begin
          gnt_any = 1'b1;
          gnt_idx = 2'(s);
        end
      end
      if (gnt_any) wb_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    busy_d      = busy_q;
    last_d      = last_q;
    gpr_we_d    = 1'b0;
    gpr_rd_d    = gpr_rd_q;
    gpr_wdata_d = gpr_wdata_q;

    // Clear lands on the same edge the register file captures the data, so a
    // consumer sees busy drop exactly when the new value becomes readable.
    if (gpr_we_q) busy_d[gpr_rd_q[3:0]] = 1'b0;
    // Same-register set/clear cannot coincide: issue_ready is low while busy.
    if (issue_fire) busy_d[issue_rd[3:0]] = 1'b1;
    busy_d[0] = 1'b0;

    if (gnt_any) begin
      last_d      = gnt_idx;
      gpr_rd_d    = wb_rd[gnt_idx];
      gpr_wdata_d = wb_data[gnt_idx];
      // A grant to x0 is consumed but never written.
      gpr_we_d    = (wb_rd[gnt_idx][3:0] != 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      last_q      <= 2'd2;
      gpr_we_q    <= 1'b0;
      gpr_rd_q    <= '0;
      gpr_wdata_q <= '0;
    end else begin
      busy_q      <= busy_d;
      last_q      <= last_d;
      gpr_we_q    <= gpr_we_d;
      gpr_rd_q    <= gpr_rd_d;
      gpr_wdata_q <= gpr_wdata_d;
    end
  end

  assign gpr_we    = gpr_we_q;
  assign gpr_rd    = gpr_rd_q;
  assign gpr_wdata = gpr_wdata_q;

endmodule

// File: tb/tb_gpr_wb_sched.sv
// Directed bench for gpr_wb_sched. Inputs change 1 time unit after the rising
// edge; all outputs are sampled on the falling edge.
module tb_gpr_wb_sched;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            issue_ready;
  logic [4:0]      rs1, rs2;
  logic            rs1_busy, rs2_busy;
  logic [2:0]      wb_valid;
  logic [2:0][4:0] wb_rd;
  logic [2:0][XLEN-1:0] wb_data;
  logic [2:0]      wb_ready;
  logic            gpr_we;
  logic [4:0]      gpr_rd;
  logic [XLEN-1:0] gpr_wdata;

  int n_chk = 0;
  int n_err = 0;

  gpr_wb_sched #(.NUM_REGS(16), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .gpr_we(gpr_we), .gpr_rd(gpr_rd), .gpr_wdata(gpr_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
    wb_valid = 3'b111;
    wb_rd[0] = 5'd1; wb_rd[1] = 5'd2; wb_rd[2] = 5'd3;
    wb_data[0] = 32'hA0; wb_data[1] = 32'hB1; wb_data[2] = 32'hC2;

    // Reset held two cycles with every requester valid.
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("rst_wb_ready", 32'(wb_ready), 32'd0);
      chk("rst_gpr_we", 32'(gpr_we), 32'd0);
      chk("rst_issue_ready", 32'(issue_ready), 32'd0);
      drive_edge();
    end
    rst = 1'b0; rs1 = 5'd5; rs2 = 5'd9;

    // Round-robin: grants 0,1,2,0,1,2; gpr_rd trails by a cycle.
    for (int i = 0; i < 6; i++) begin
      smp();
      if (i == 0) begin
        chk("post_rst_issue_ready", 32'(issue_ready), 32'd1);
        chk("post_rst_rs1_busy", 32'(rs1_busy), 32'd0);
        chk("post_rst_rs2_busy", 32'(rs2_busy), 32'd0);
        chk("post_rst_gpr_we", 32'(gpr_we), 32'd0);
        chk("post_rst_gpr_rd", 32'(gpr_rd), 32'd0);
        chk("post_rst_gpr_wdata", gpr_wdata, 32'd0);
      end else begin
        chk("rr_gpr_we", 32'(gpr_we), 32'd1);
        chk("rr_gpr_rd", 32'(gpr_rd), 32'((i - 1) % 3 + 1));
      end
      chk("rr_grant", 32'(wb_ready), 32'(1 << (i % 3)));
      drive_edge();
    end
    wb_valid = 3'b000;
    smp();
    chk("rr_last_gpr_rd", 32'(gpr_rd), 32'd3);
    chk("rr_last_wdata", gpr_wdata, 32'hC2);
    chk("rr_idle_ready", 32'(wb_ready), 32'd0);

    // Hazard on rd=5.
    drive_edge();
    issue_valid = 1'b1; issue_rd = 5'd5;
    smp();
    chk("hz_issue_ready", 32'(issue_ready), 32'd1);
    chk("hz_gpr_we_idle", 32'(gpr_we), 32'd0);
    drive_edge();
    rs1 = 5'd5;
    smp();
    chk("hz_rs1_busy", 32'(rs1_busy), 32'd1);
    chk("hz_issue_refused", 32'(issue_ready), 32'd0);
    drive_edge();
    issue_valid = 1'b0;
    wb_valid = 3'b001; wb_rd[0] = 5'd5; wb_data[0] = 32'hDEADBEEF;
    smp();  // cycle N
    chk("hz_grant", 32'(wb_ready), 32'b001);
    chk("hz_busy_N", 32'(rs1_busy), 32'd1);
    drive_edge();
    wb_valid = 3'b000;
    smp();  // N+1
    chk("hz_we_N1", 32'(gpr_we), 32'd1);
    chk("hz_rd_N1", 32'(gpr_rd), 32'd5);
    chk("hz_data_N1", gpr_wdata, 32'hDEADBEEF);
    chk("hz_busy_N1", 32'(rs1_busy), 32'd1);
    drive_edge();
    smp();  // N+2
    chk("hz_busy_N2", 32'(rs1_busy), 32'd0);
    chk("hz_we_N2", 32'(gpr_we), 32'd0);

    // x0: issue rd=0 then LSU write to rd=0.
    drive_edge();
    issue_valid = 1'b1; issue_rd = 5'd0; rs1 = 5'd0;
    smp();
    chk("x0_issue_ready", 32'(issue_ready), 32'd1);
    drive_edge();
    issue_valid = 1'b0;
    wb_valid = 3'b010; wb_rd[1] = 5'd0; wb_data[1] = 32'h1234;
    smp();
    chk("x0_rs1_busy", 32'(rs1_busy), 32'd0);
    chk("x0_issue_ready2", 32'(issue_ready), 32'd1);
    chk("x0_grant", 32'(wb_ready), 32'b010);
    drive_edge();
    wb_valid = 3'b000;
    smp();
    chk("x0_gpr_we", 32'(gpr_we), 32'd0);
    chk("x0_gpr_wdata", gpr_wdata, 32'h1234);

    // Same-edge: set busy[7] while gpr_we clears busy[3].
    drive_edge();
    issue_valid = 1'b1; issue_rd = 5'd3;
    drive_edge();
    issue_valid = 1'b0;
    wb_valid = 3'b100; wb_rd[2] = 5'd3; wb_data[2] = 32'h33;
    smp();
    chk("se_csr_grant", 32'(wb_ready), 32'b100);
    drive_edge();
    wb_valid = 3'b000;
    issue_valid = 1'b1; issue_rd = 5'd7; rs2 = 5'd3;
    smp();
    chk("se_gpr_we", 32'(gpr_we), 32'd1);
    chk("se_gpr_rd", 32'(gpr_rd), 32'd3);
    chk("se_rs2_busy_pre", 32'(rs2_busy), 32'd1);
    chk("se_issue7_ready", 32'(issue_ready), 32'd1);
    drive_edge();
    issue_valid = 1'b0; rs1 = 5'd7;
    smp();
    chk("se_busy7", 32'(rs1_busy), 32'd1);
    chk("se_busy3", 32'(rs2_busy), 32'd0);

    // Reset mid-operation: rd=9 busy, grant in flight, then reset.
    drive_edge();
    issue_valid = 1'b1; issue_rd = 5'd9;
    drive_edge();
    issue_valid = 1'b0;
    wb_valid = 3'b001; wb_rd[0] = 5'd9; wb_data[0] = 32'h99;
    rs1 = 5'd9; rs2 = 5'd7;
    smp();
    chk("rm_busy9", 32'(rs1_busy), 32'd1);
    chk("rm_grant", 32'(wb_ready), 32'b001);
    drive_edge();
    rst = 1'b1; wb_valid = 3'b111;
    wb_rd[0] = 5'd1; wb_rd[1] = 5'd2; wb_rd[2] = 5'd3;
    smp();
    chk("rm_inflight_we", 32'(gpr_we), 32'd1);
    chk("rm_rst_wb_ready", 32'(wb_ready), 32'd0);
    chk("rm_rst_issue_ready", 32'(issue_ready), 32'd0);
    drive_edge();
    rst = 1'b0;
    smp();
    chk("rm_gpr_we", 32'(gpr_we), 32'd0);
    chk("rm_gpr_rd", 32'(gpr_rd), 32'd0);
    chk("rm_rs1_busy9", 32'(rs1_busy), 32'd0);
    chk("rm_rs2_busy7", 32'(rs2_busy), 32'd0);
    chk("rm_first_grant", 32'(wb_ready), 32'b001);
    drive_edge();
    wb_valid = 3'b000;
    smp();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Bound on total runtime in case the stimulus stalls.
  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
